motion_ctrl: RTL and testbench
==============================

MOTION_CTRL -- requirements
Module: motion_ctrl

Interface
REQ-001 SHALL have parameter MOVE_TICKS, default 64: clk cycles to travel one floor (2 s at 32 Hz); legal 2..255.
REQ-002 SHALL have parameter DOOR_TICKS, default 96: clk cycles the door stays open (3 s at 32 Hz); legal 2..255.
REQ-003 SHALL have port clk, input, 1 bit: 32 Hz system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port up_need, input, 1 bit: upward demand from the request stage.
REQ-006 SHALL have port down_need, input, 1 bit: downward demand from the request stage.
REQ-007 SHALL have port all_req, input, 4 bits: one-hot-per-floor OR of all valid requests; bit0 = floor 1.
REQ-008 SHALL have port door_hold, input, 1 bit: door-open button; used only per REQ-024.
REQ-009 SHALL have port position, output, 4 bits: registered one-hot current floor.
REQ-010 SHALL have port ud_mode, output, 2 bits: registered run mode; 00 stop, 01 up, 10 down; 11 never driven.
REQ-011 SHALL have port door_open, output, 1 bit: registered, high while the door is open.
REQ-012 SHALL have port floor_num, output, 2 bits: registered binary of position (0 = floor 1).

Function
REQ-013 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR with one shared tick counter (8 bits).
REQ-014 IDLE SHALL be checked in this priority: (all_req & position)!=0 -> DOOR; else up_need -> MOVE_UP; else down_need -> MOVE_DOWN; else stay. The counter SHALL be cleared on entry to any state.
REQ-015 Simultaneous up_need and down_need in IDLE SHALL select MOVE_UP.
REQ-016 ud_mode SHALL be 01 in MOVE_UP, 10 in MOVE_DOWN and 00 in IDLE and DOOR, updated in the same edge as the state.
REQ-017 In MOVE states the counter SHALL increment each cycle. When it equals MOVE_TICKS-1, position SHALL shift one floor (left for up, right for down), floor_num SHALL follow in the same edge, and the counter SHALL clear.
REQ-018 In the first MOVE cycle after a shift (counter==0), (all_req & position)!=0 SHALL cause a transition to DOOR at the next edge, before any further travel.
REQ-019 MOVE_UP at position 4'b1000, or MOVE_DOWN at 4'b0001, SHALL go to IDLE without shifting; position SHALL never wrap or become zero or multi-hot.
REQ-020 In MOVE state, if the MOVE_TICKS window completes with no request anywhere (all_req==0), the block SHALL go to IDLE instead of shifting.
REQ-021 In DOOR, door_open=1 and the counter SHALL count to DOOR_TICKS-1, then go to IDLE with door_open=0. The door interval SHALL be exactly DOOR_TICKS cycles.
REQ-022 Input changes during DOOR SHALL NOT shorten the door interval.

Reset
REQ-023 When rst_n is low, at any time including mid-move or mid-door, the block SHALL immediately set state=IDLE, position=4'b0001, floor_num=0, ud_mode=00, door_open=0 and counter=0. It SHALL resume at the first clk edge after rst_n rises.

Configuration
REQ-024 With DOOR_HOLD_EN defined, door_hold=1 in DOOR SHALL clear the counter every cycle, holding the door open until DOOR_TICKS cycles after release. With DOOR_HOLD_EN undefined, door_hold SHALL be ignored and the port SHALL remain present.

Structure
REQ-025 The shared package elev_pkg SHALL hold the ud_mode codes (UD_STOP, UD_UP, UD_DOWN), the state encoding and the floor one-hot constants FLOOR1..FLOOR4, for use by the request stage and this block.
REQ-026 The counter SHALL be sub-module tick_counter (ports clr, en, count) with a done flag at terminal value; the FSM SHALL stay in motion_ctrl.

Verification (MOVE_TICKS=4, DOOR_TICKS=6)
REQ-027 Reset, then up_need=1 and all_req=0100 -> ud_mode=01 next edge; position=0010 after 4 cycles and 0100 after 8; DOOR the cycle after; door_open high for 6 cycles; then IDLE, ud_mode=00.
REQ-028 At floor 3, down_need=1 and all_req=0001 -> ud_mode=10; position steps 0010 then 0001; door opens; position never reaches 0000.
REQ-029 IDLE with up_need=down_need=1 and all_req=1001 at floor 2 -> MOVE_UP selected; at 1000 with no further up request -> DOOR, never 0000.
REQ-030 rst_n pulsed low mid-move at position 0100 -> position=0001, ud_mode=00, door_open=0 immediately, with no clk edge needed.
REQ-031 With DOOR_HOLD_EN, door_hold high for 10 cycles in DOOR -> door_open stays high for 10+6 cycles. Without the macro -> door_open high for exactly 6 cycles.

Source files
------------

// File: rtl/elev_pkg.sv
// Shared elevator definitions: run-mode codes, motion FSM state encoding,
// one-hot floor constants and a one-hot to binary floor helper.
package elev_pkg;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [3:0] FLOOR1 = 4'b0001;
    localparam logic [3:0] FLOOR2 = 4'b0010;
    localparam logic [3:0] FLOOR3 = 4'b0100;
    localparam logic [3:0] FLOOR4 = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_MOVE_UP   = 2'b01,
        ST_MOVE_DOWN = 2'b10,
        ST_DOOR      = 2'b11
    } state_t;

    function automatic logic [1:0] onehot_to_bin(input logic [3:0] oh);
        logic [1:0] bin;
        bin = 2'd0;
        case (oh)
            FLOOR2:  bin = 2'd1;
            FLOOR3:  bin = 2'd2;
            FLOOR4:  bin = 2'd3;
            default: bin = 2'd0;
        endcase
        return bin;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// 8-bit tick counter shared by travel and door timing; done flags the
// terminal value supplied by the owner of the counter.
module tick_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] term,
    output logic [7:0] count,
    output logic       done
);

    // counter register: clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end else begin
            count <= count;
        end
    end

    assign done = (count == term);

endmodule

// File: rtl/motion_ctrl.sv
// Elevator motion controller: travel, floor tracking and door timing.
// Define DOOR_HOLD_EN to let door_hold keep the door open while pressed.
module motion_ctrl
    import elev_pkg::*;
#(
    parameter int MOVE_TICKS = 64,
    parameter int DOOR_TICKS = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_need,
    input  logic       down_need,
    input  logic [3:0] all_req,
    input  logic       door_hold,
    output logic [3:0] position,
    output logic [1:0] ud_mode,
    output logic       door_open,
    output logic [1:0] floor_num
);

    localparam logic [7:0] MOVE_TERM = 8'(MOVE_TICKS - 1);
    localparam logic [7:0] DOOR_TERM = 8'(DOOR_TICKS - 1);

    state_t     state_r;
    logic [3:0] position_r;
    logic [1:0] ud_mode_r;
    logic       door_open_r;
    logic [1:0] floor_num_r;

    logic [7:0] count_s;
    logic [7:0] term_s;
    logic       done_s;
    logic       clr_s;
    logic       en_s;
    logic       hold_s;
    logic       arrive_s;
    logic       at_end_s;
    logic [3:0] nxt_pos_s;

`ifdef DOOR_HOLD_EN
    assign hold_s = door_hold;
`else
    logic unused_hold_s;
    assign hold_s        = 1'b0;
    assign unused_hold_s = door_hold;
`endif

    // A request for the floor we just reached only counts on the first travel cycle
    assign arrive_s  = (count_s == 8'd0) && ((all_req & position_r) != 4'b0000);
    assign at_end_s  = ((state_r == ST_MOVE_UP)   && (position_r == FLOOR4)) ||
                       ((state_r == ST_MOVE_DOWN) && (position_r == FLOOR1));
    assign nxt_pos_s = (state_r == ST_MOVE_DOWN) ? {1'b0, position_r[3:1]}
                                                 : {position_r[2:0], 1'b0};
    assign term_s    = (state_r == ST_DOOR) ? DOOR_TERM : MOVE_TERM;

    tick_counter u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (en_s),
        .term  (term_s),
        .count (count_s),
        .done  (done_s)
    );

    // counter control: clear on every state change, floor shift or door hold
    always_comb begin
        clr_s = 1'b1;
        en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clr_s = 1'b1;
                en_s  = 1'b0;
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                clr_s = arrive_s | at_end_s | done_s;
                en_s  = 1'b1;
            end
            ST_DOOR: begin
                clr_s = done_s | hold_s;
                en_s  = 1'b1;
            end
            default: begin
                clr_s = 1'b1;
                en_s  = 1'b0;
            end
        endcase
    end

    // motion FSM with registered position, mode, door and floor outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            position_r  <= FLOOR1;
            ud_mode_r   <= UD_STOP;
            door_open_r <= 1'b0;
            floor_num_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((all_req & position_r) != 4'b0000) begin
                        state_r     <= ST_DOOR;
                        door_open_r <= 1'b1;
                        ud_mode_r   <= UD_STOP;
                    end else if (up_need) begin
                        state_r   <= ST_MOVE_UP;
                        ud_mode_r <= UD_UP;
                    end else if (down_need) begin
                        state_r   <= ST_MOVE_DOWN;
                        ud_mode_r <= UD_DOWN;
                    end else begin
                        state_r   <= ST_IDLE;
                        ud_mode_r <= UD_STOP;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (arrive_s) begin
                        state_r     <= ST_DOOR;
                        door_open_r <= 1'b1;
                        ud_mode_r   <= UD_STOP;
                    end else if (at_end_s || (done_s && (all_req == 4'b0000))) begin
                        state_r   <= ST_IDLE;
                        ud_mode_r <= UD_STOP;
                    end else if (done_s) begin
                        position_r  <= nxt_pos_s;
                        floor_num_r <= onehot_to_bin(nxt_pos_s);
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DOOR: begin
                    if (done_s && !hold_s) begin
                        state_r     <= ST_IDLE;
                        door_open_r <= 1'b0;
                    end else begin
                        door_open_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    position_r  <= FLOOR1;
                    ud_mode_r   <= UD_STOP;
                    door_open_r <= 1'b0;
                    floor_num_r <= 2'd0;
                end
            endcase
        end
    end

    assign position  = position_r;
    assign ud_mode   = ud_mode_r;
    assign door_open = door_open_r;
    assign floor_num = floor_num_r;

endmodule

// File: tb/tb_motion_ctrl.sv
// Self-checking bench for motion_ctrl (MOVE_TICKS=4, DOOR_TICKS=6) with a
// floor/phase model compared every cycle plus directed literal checks.
module tb_motion_ctrl;

    localparam int MT = 4;
    localparam int DT = 6;
    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    typedef struct packed {
        int floor;
        int mode;
        int left;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_need = 1'b0;
    logic       down_need = 1'b0;
    logic [3:0] all_req = 4'b0000;
    logic       door_hold = 1'b0;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic       door_open;
    logic [1:0] floor_num;

    int   checks = 0;
    int   errors = 0;
    mst_t m = '0;

    motion_ctrl #(.MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_need   (up_need),
        .down_need (down_need),
        .all_req   (all_req),
        .door_hold (door_hold),
        .position  (position),
        .ud_mode   (ud_mode),
        .door_open (door_open),
        .floor_num (floor_num)
    );

    always #5 clk = ~clk;

    // floor as an integer, mode as a small enum, left = cycles remaining in phase
    function automatic mst_t model_next(mst_t s, logic up, logic dn, logic [3:0] req, logic hold);
        mst_t n;
        logic here;
        int   dir;
        logic hold_on;
        n    = s;
        here = |(req & 4'(1 << s.floor));
`ifdef DOOR_HOLD_EN
        hold_on = hold;
`else
        hold_on = 1'b0 & hold;
`endif
        case (s.mode)
            M_IDLE: begin
                if (here)    begin n.mode = M_DOOR; n.left = DT; end
                else if (up) begin n.mode = M_UP;   n.left = MT; end
                else if (dn) begin n.mode = M_DOWN; n.left = MT; end
            end
            M_UP, M_DOWN: begin
                dir = (s.mode == M_UP) ? 1 : -1;
                if (s.left == MT && here) begin
                    n.mode = M_DOOR; n.left = DT;
                end else if (s.floor + dir < 0 || s.floor + dir > 3) begin
                    n.mode = M_IDLE;
                end else if (s.left == 1) begin
                    if (req == 4'b0000) n.mode = M_IDLE;
                    else begin n.floor = s.floor + dir; n.left = MT; end
                end else begin
                    n.left = s.left - 1;
                end
            end
            default: begin
                if (hold_on)          n.left = DT;
                else if (s.left == 1) n.mode = M_IDLE;
                else                  n.left = s.left - 1;
            end
        endcase
        return n;
    endfunction

    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m = '0;
            else        m = model_next(m, up_need, down_need, all_req, door_hold);
        end
    end

    initial begin : cmp_proc
        logic [8:0] exp_v;
        logic [8:0] act_v;
        forever begin
            @(negedge clk);
            exp_v = {4'(1 << m.floor),
                     (m.mode == M_UP) ? 2'b01 : ((m.mode == M_DOWN) ? 2'b10 : 2'b00),
                     (m.mode == M_DOOR) ? 1'b1 : 1'b0,
                     2'(m.floor)};
            act_v = {position, ud_mode, door_open, floor_num};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model t=%0t: got pos=%b ud=%b door=%b fn=%b, expected pos=%b ud=%b door=%b fn=%b",
                         $time, act_v[8:5], act_v[4:3], act_v[2], act_v[1:0],
                         exp_v[8:5], exp_v[4:3], exp_v[2], exp_v[1:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // called in the first door cycle; counts door-open cycles over a bounded window
    task automatic measure_door(input int release_at, output int len);
        len = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == release_at) door_hold = 1'b0;
            if (door_open) len++;
            step(1);
        end
    endtask

    initial begin : stim
        int n;
        int exp_hold_len;
        step(2);
        chk("reset_pos", position, 4'b0001);
        chk("reset_ud", ud_mode, 2'b00);
        chk("reset_door", door_open, 1'b0);
        chk("reset_fn", floor_num, 2'd0);
        rst_n = 1'b1;
        step(1);

        // floor 1 up to floor 3, door, idle
        up_need = 1'b1; all_req = 4'b0100;
        step(1); chk("up_mode", ud_mode, 2'b01);
        step(3); chk("up_wait_pos", position, 4'b0001);
        step(1); chk("up_f2", position, 4'b0010); chk("up_f2_fn", floor_num, 2'd1);
        step(4); chk("up_f3", position, 4'b0100); chk("up_f3_fn", floor_num, 2'd2);
        step(1); chk("f3_door", door_open, 1'b1); chk("f3_door_ud", ud_mode, 2'b00);
        up_need = 1'b0; all_req = 4'b0000;
        step(5); chk("f3_door_last", door_open, 1'b1);
        step(1); chk("f3_door_closed", door_open, 1'b0); chk("f3_idle_ud", ud_mode, 2'b00);

        // floor 3 down to floor 1
        down_need = 1'b1; all_req = 4'b0001;
        step(1); chk("dn_mode", ud_mode, 2'b10);
        step(4); chk("dn_f2", position, 4'b0010);
        step(4); chk("dn_f1", position, 4'b0001);
        step(1); chk("f1_door", door_open, 1'b1);
        down_need = 1'b0; all_req = 4'b0000;
        measure_door(0, n); chk("f1_door_len", n, 6);

        // to floor 2, then simultaneous demands choose up and stop at floor 4
        up_need = 1'b1; all_req = 4'b0010;
        step(1); chk("f2_mode", ud_mode, 2'b01);
        step(4); chk("f2_pos", position, 4'b0010);
        step(1); chk("f2_door", door_open, 1'b1);
        up_need = 1'b0; all_req = 4'b0000;
        measure_door(0, n);
        up_need = 1'b1; down_need = 1'b1; all_req = 4'b1001;
        step(1); chk("both_sel_up", ud_mode, 2'b01);
        step(8); chk("top_pos", position, 4'b1000); chk("top_fn", floor_num, 2'd3);
        step(1); chk("top_door", door_open, 1'b1); chk("top_door_pos", position, 4'b1000);
        up_need = 1'b0; down_need = 1'b0; all_req = 4'b0000;
        measure_door(0, n); chk("top_door_len", n, 6);

        // up demand at the top floor returns to idle without shifting
        up_need = 1'b1;
        step(1); chk("top_up_mode", ud_mode, 2'b01);
        up_need = 1'b0;
        step(1); chk("top_up_idle", ud_mode, 2'b00); chk("top_up_pos", position, 4'b1000);

        // request withdrawn mid-window: back to idle, no shift
        down_need = 1'b1; all_req = 4'b0001;
        step(1); chk("wd_mode", ud_mode, 2'b10);
        step(2); down_need = 1'b0; all_req = 4'b0000;
        step(2); chk("wd_pos", position, 4'b1000); chk("wd_ud", ud_mode, 2'b00);

        // asynchronous reset mid-move at floor 3
        down_need = 1'b1; all_req = 4'b0001;
        step(5); chk("rst_pre_pos", position, 4'b0100);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("arst_pos", position, 4'b0001);
        chk("arst_ud", ud_mode, 2'b00);
        chk("arst_door", door_open, 1'b0);
        chk("arst_fn", floor_num, 2'd0);
        step(1);
        rst_n = 1'b1; down_need = 1'b0; all_req = 4'b0000;
        step(2);

        // door_hold held for the first 10 door cycles
        all_req = 4'b0001;
        step(1); chk("hold_door", door_open, 1'b1);
        all_req = 4'b0000; door_hold = 1'b1;
`ifdef DOOR_HOLD_EN
        exp_hold_len = 16;
`else
        exp_hold_len = 6;
`endif
        measure_door(10, n); chk("hold_door_len", n, exp_hold_len);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
